// File: rtl/lcd_scan_driver.sv
// Raster generator and power-up sequencer for an RGB LCD panel: panel reset, blank warm-up
// frames, then live display with pixel requests issued one cycle ahead of DE.
module lcd_scan_driver #(
  parameter int H_SYNC        = 41,
  parameter int H_BACK        = 2,
  parameter int H_DISP        = 480,
  parameter int H_FRONT       = 2,
  parameter int V_SYNC        = 10,
  parameter int V_BACK        = 2,
  parameter int V_DISP        = 272,
  parameter int V_FRONT       = 2,
  parameter int RST_CYCLES    = 1000,
  parameter int WARMUP_FRAMES = 2
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        lcd_rst,
  output logic        lcd_bl,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_L  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_L  = 11'(V_SYNC);
  // Requests lead DE by one pixel, so the request window starts one column early.
  localparam logic [10:0] REQ_BEG   = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] REQ_END   = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0] V_ACT_BEG = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_END = 11'(V_SYNC + V_BACK + V_DISP);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int FRM_W = $clog2(WARMUP_FRAMES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(WARMUP_FRAMES - 1);

  typedef enum logic [1:0] {S_RST, S_WARM, S_RUN} state_t;

  state_t           state, state_next;
  logic [RST_W-1:0] rst_cnt, rst_cnt_next;
  logic [FRM_W-1:0] frm_cnt, frm_cnt_next;
  logic [10:0]      h_cnt, h_cnt_next;
  logic [10:0]      v_cnt, v_cnt_next;
  logic             line_end, frame_end, v_act, data_req;

  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) begin
      state   <= S_RST;
      rst_cnt <= '0;
      frm_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      lcd_de  <= 1'b0;
    end else begin
      state   <= state_next;
      rst_cnt <= rst_cnt_next;
      frm_cnt <= frm_cnt_next;
      h_cnt   <= h_cnt_next;
      v_cnt   <= v_cnt_next;
      lcd_de  <= data_req;
    end
  end

  always_comb begin
    state_next   = state;
    rst_cnt_next = rst_cnt;
    frm_cnt_next = frm_cnt;
    h_cnt_next   = h_cnt;
    v_cnt_next   = v_cnt;
    line_end     = (h_cnt == H_LAST);
    frame_end    = line_end && (v_cnt == V_LAST);
    case (state)
      S_RST: begin
        h_cnt_next = '0;
        v_cnt_next = '0;
        if (rst_cnt == RST_LAST) state_next = S_WARM;
        else rst_cnt_next = rst_cnt + 1'b1;
      end
      default: begin
        h_cnt_next = line_end ? 11'd0 : h_cnt + 11'd1;
        if (line_end) v_cnt_next = frame_end ? 11'd0 : v_cnt + 11'd1;
        if (state == S_WARM && frame_end) begin
          frm_cnt_next = frm_cnt + 1'b1;
          if (frm_cnt == FRM_LAST) state_next = S_RUN;
        end
      end
    endcase
  end

  assign v_act    = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign data_req = (state == S_RUN) && v_act && (h_cnt >= REQ_BEG) && (h_cnt < REQ_END);

  assign pixel_xpos  = data_req ? (h_cnt - REQ_BEG) : 11'd0;
  // Row stays valid-looking through blanking so the line buffers can prefill.
  assign pixel_ypos  = v_act ? (v_cnt - V_ACT_BEG) : 11'd0;
  assign h_disp      = 11'(H_DISP);
  assign v_disp      = 11'(V_DISP);
  assign lcd_hs      = (state == S_RST) || (h_cnt >= H_SYNC_L);
  assign lcd_vs      = (state == S_RST) || (v_cnt >= V_SYNC_L);
  assign lcd_rst     = (state != S_RST);
  assign lcd_bl      = (state == S_RUN);
  assign frame_start = (state == S_RUN) && (h_cnt == 11'd0) && (v_cnt == 11'd0);
  assign lcd_rgb     = lcd_de ? pixel_data : 24'h0;

endmodule

// File: tb/tb_lcd_scan_driver.sv
// Scoreboard bench for lcd_scan_driver on a shrunken raster; the reference derives every
// output from the number of clock edges since reset release.
module tb_lcd_scan_driver;

  localparam int HS = 3, HB = 2, HD = 8, HF = 2;
  localparam int VS = 2, VB = 1, VD = 4, VF = 1;
  localparam int RSTC = 20, WARM = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FT = HT * VT;
  localparam int NCYC = 1200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pixel_data = 24'h0;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic        lcd_hs, lcd_vs, lcd_de, lcd_rst, lcd_bl, frame_start;
  logic [23:0] lcd_rgb;

  typedef struct {
    int          cyc;
    logic [10:0] x, y;
    logic        hs, vs, de, rst, bl, fs;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  lcd_scan_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .RST_CYCLES(RSTC), .WARMUP_FRAMES(WARM)
  ) dut (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .h_disp(h_disp), .v_disp(v_disp),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .lcd_rst(lcd_rst), .lcd_bl(lcd_bl), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Position in the power-up timeline t edges after the reset edge.
  function automatic void locate(input int t, output bit pre, output int h, output int v,
                                 output bit run);
    int u;
    pre = (t < RSTC);
    h = 0; v = 0; run = 1'b0;
    if (!pre) begin
      u   = t - RSTC;
      h   = u % HT;
      v   = (u / HT) % VT;
      run = (u / FT) >= WARM;
    end
  endfunction

  function automatic bit req_at(input int t);
    bit pre, run;
    int h, v;
    locate(t, pre, h, v, run);
    return run && v >= VS + VB && v < VS + VB + VD && h >= HS + HB - 1 && h < HS + HB + HD - 1;
  endfunction

  function automatic int xpos_at(input int t);
    bit pre, run;
    int h, v;
    locate(t, pre, h, v, run);
    return req_at(t) ? h - (HS + HB - 1) : 0;
  endfunction

  task automatic chk(input int cyc, input string nm, input logic [23:0] act, input logic [23:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL cyc=%0d %s got=%0h want=%0h", cyc, nm, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.cyc, "xpos", 24'(pixel_xpos), 24'(e.x));
        chk(e.cyc, "ypos", 24'(pixel_ypos), 24'(e.y));
        chk(e.cyc, "hs", 24'(lcd_hs), 24'(e.hs));
        chk(e.cyc, "vs", 24'(lcd_vs), 24'(e.vs));
        chk(e.cyc, "de", 24'(lcd_de), 24'(e.de));
        chk(e.cyc, "rgb", lcd_rgb, e.rgb);
        chk(e.cyc, "lcd_rst", 24'(lcd_rst), 24'(e.rst));
        chk(e.cyc, "bl", 24'(lcd_bl), 24'(e.bl));
        chk(e.cyc, "frame_start", 24'(frame_start), 24'(e.fs));
        chk(e.cyc, "h_disp", 24'(h_disp), 24'(HD));
        chk(e.cyc, "v_disp", 24'(v_disp), 24'(VD));
        $display("cyc=%0d x=%0d y=%0d hs=%b vs=%b de=%b rgb=%06h rst=%b bl=%b fs=%b",
                 e.cyc, pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb,
                 lcd_rst, lcd_bl, lcd_de ? 1'b1 : frame_start);
      end
    end
  end

  initial begin
    int t = 0;
    int rs;
    bit pre, run;
    int h, v;
    exp_t e;
    // Second reset lands somewhere in live display (run begins near cycle 262).
    rs = 320 + int'($urandom_range(0, 80));
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      if (!rst_n) t = 0;
      else t++;
      #1;
      pixel_data = {13'($urandom), (t > 0) ? 11'(xpos_at(t - 1)) : 11'd0};
      locate(t, pre, h, v, run);
      e.cyc = c;
      e.x   = 11'(xpos_at(t));
      e.y   = (v >= VS + VB && v < VS + VB + VD) ? 11'(v - (VS + VB)) : 11'd0;
      e.hs  = pre || h >= HS;
      e.vs  = pre || v >= VS;
      e.de  = (t > 0) && req_at(t - 1);
      e.rgb = e.de ? pixel_data : 24'h0;
      e.rst = !pre;
      e.bl  = run;
      e.fs  = run && h == 0 && v == 0;
      sb.push_back(e);
      rst_n = !(c < 2 || (c >= rs && c < rs + 3));
    end
    @(negedge clk);
    #1;
    chk(NCYC, "sb_drained", 24'(sb.size()), 24'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
